// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// An owner keeps the port for up to MAX_BURST beats; full stalls without losing ownership.
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   sel_inc;
    logic [PTR_W-1:0]   owner_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_REQ-1:0] grant_c;

    // First active requester scanning upward from rr_ptr with wrap-around
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!sel_valid && req[PTR_W'(idx)]) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'(idx);
            end
        end
    end

    assign sel_inc   = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    assign cnt_inc   = burst_cnt_q + CNT_W'(1);

    // Next-state and grant decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        owner_d     = owner_q;
        grant_c     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!full && sel_valid) begin
                    grant_c[sel_idx] = 1'b1;
                    owner_d          = sel_idx;
                    burst_cnt_d      = CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = sel_inc;
                    end else begin
                        state_d = ST_OWN;
                    end
                end
            end
            ST_OWN: begin
                if (req[owner_q]) begin
                    if (!full) begin
                        grant_c[owner_q] = 1'b1;
                        burst_cnt_d      = cnt_inc;
                        if (cnt_inc == CNT_W'(MAX_BURST)) begin
                            state_d  = ST_IDLE;
                            rr_ptr_d = owner_inc;
                        end
                    end
                end else begin
                    // Owner left: give up the port, costing one bubble cycle
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            owner_q     <= owner_d;
        end
    end

    assign grant    = rstn ? grant_c : '0;
    assign write_en = |grant;
    assign busy     = (state_q == ST_OWN);
    assign owner    = owner_q;

    // Grant is one-hot or zero, so an OR of gated slices forms the mux
    always_comb begin
        write_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                write_data = write_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: MAX_BURST=4 instance plus a MAX_BURST=1 instance.
module tb_fifo_write_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;

    typedef struct packed {
        logic [NR-1:0] g;
        logic [DW-1:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic             full;

    logic [NR-1:0]    a_grant, b_grant;
    logic             a_we, b_we;
    logic [DW-1:0]    a_wd, b_wd;
    logic             a_busy, b_busy;
    logic [1:0]       a_owner, b_owner;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut_a (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .full(full),
        .grant(a_grant), .write_en(a_we), .write_data(a_wd), .busy(a_busy), .owner(a_owner)
    );

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut_b (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .full(full),
        .grant(b_grant), .write_en(b_we), .write_data(b_wd), .busy(b_busy), .owner(b_owner)
    );

    // Drive one cycle of stimulus and queue the expected grant and data word
    task automatic drive(input logic [NR-1:0] r, input logic f, input logic [NR-1:0] eg);
        exp_t e;
        req      = r;
        full     = f;
        req_data = $urandom;
        e.g      = eg;
        e.d      = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (eg[i]) e.d = req_data[i*DW +: DW];
        end
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        req  = '0;
        full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0; req = 4'b1111; full = 1'b0; req_data = 32'hA5A5_A5A5;
        #2;
        total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", a_grant); end
        total++; if (a_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", a_we); end
        total++; if (a_wd !== 8'h00) begin bad++; $display("FAIL rst_wd got=%h exp=00", a_wd); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
        total++; if (a_owner !== 2'd0) begin bad++; $display("FAIL rst_owner got=%0d exp=0", a_owner); end
        @(posedge clk); #1 rstn = 1'b1;
        // Requester 2 runs one full burst and starts a second one
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, 1'b0, 4'b0100);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (a_grant !== e.g) begin bad++; $display("FAIL rstpre_grant k=%0d got=%b exp=%b", k, a_grant, e.g); end
            @(posedge clk); #1;
        end
        req = 4'b1111;
        rstn = 1'b0;
        #1;
        total++; if (a_grant !== 4'b0000) begin bad++; $display("FAIL midrst_grant got=%b exp=0000", a_grant); end
        total++; if (a_we !== 1'b0) begin bad++; $display("FAIL midrst_we got=%b exp=0", a_we); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
        total++; if (a_owner !== 2'd0) begin bad++; $display("FAIL midrst_owner got=%0d exp=0", a_owner); end
        @(posedge clk); #1 rstn = 1'b1;
        drive(4'b1111, 1'b0, 4'b0001);
        @(negedge clk);
        e = sb.pop_front();
        total++; if (a_grant !== e.g) begin bad++; $display("FAIL postrst_grant got=%b exp=%b", a_grant, e.g); end
        total++; if (a_wd !== e.d) begin bad++; $display("FAIL postrst_wd got=%h exp=%h", a_wd, e.d); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_streamer();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            drive(4'b0010, 1'b0, 4'b0010);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (a_grant !== e.g) begin bad++; $display("FAIL single_grant k=%0d got=%b exp=%b", k, a_grant, e.g); end
            total++; if (a_wd !== e.d) begin bad++; $display("FAIL single_wd k=%0d got=%h exp=%h", k, a_wd, e.d); end
            total++; if (a_busy !== ((k % 4) != 0)) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, a_busy, (k % 4) != 0); end
            if (k > 0) begin
                total++; if (a_owner !== 2'd1) begin bad++; $display("FAIL single_owner k=%0d got=%0d exp=1", k, a_owner); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_active();
        exp_t e;
        logic [NR-1:0] eg;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            eg = 4'b0001 << ((k / 4) % 4);
            drive(4'b1111, 1'b0, eg);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (a_grant !== e.g) begin bad++; $display("FAIL all_grant k=%0d got=%b exp=%b", k, a_grant, e.g); end
            total++; if (a_we !== 1'b1) begin bad++; $display("FAIL all_we k=%0d got=%b exp=1", k, a_we); end
            total++; if (a_wd !== e.d) begin bad++; $display("FAIL all_wd k=%0d got=%h exp=%h", k, a_wd, e.d); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_mid_burst();
        exp_t e;
        logic          f_tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [NR-1:0] g_tab[9]  = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                     4'b0100, 4'b0100, 4'b1000};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(4'b1100, f_tab[k], g_tab[k]);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (a_grant !== e.g) begin bad++; $display("FAIL full_grant k=%0d got=%b exp=%b", k, a_grant, e.g); end
            total++; if (a_we !== (|e.g)) begin bad++; $display("FAIL full_we k=%0d got=%b exp=%b", k, a_we, |e.g); end
            total++; if (a_wd !== e.d) begin bad++; $display("FAIL full_wd k=%0d got=%h exp=%h", k, a_wd, e.d); end
            if (k == 4) begin
                total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL full_stall_busy got=%b exp=1", a_busy); end
                total++; if (a_owner !== 2'd2) begin bad++; $display("FAIL full_stall_owner got=%0d exp=2", a_owner); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_owner_drop();
        exp_t e;
        logic [NR-1:0] r_tab[5] = '{4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1010};
        logic [NR-1:0] g_tab[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(r_tab[k], 1'b0, g_tab[k]);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (a_grant !== e.g) begin bad++; $display("FAIL drop_grant k=%0d got=%b exp=%b", k, a_grant, e.g); end
            total++; if (a_wd !== e.d) begin bad++; $display("FAIL drop_wd k=%0d got=%h exp=%h", k, a_wd, e.d); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_burst_one();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b0101, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (b_grant !== e.g) begin bad++; $display("FAIL mb1_grant k=%0d got=%b exp=%b", k, b_grant, e.g); end
            total++; if (b_wd !== e.d) begin bad++; $display("FAIL mb1_wd k=%0d got=%h exp=%h", k, b_wd, e.d); end
            total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL mb1_busy k=%0d got=%b exp=0", k, b_busy); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rstn = 1'b0; req = '0; full = 1'b0; req_data = '0;
        #1;
        test_reset();
        test_single_streamer();
        test_all_active();
        test_full_mid_burst();
        test_owner_drop();
        test_burst_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
